// File: rtl/chip8_mem_arbiter.sv
// Arbitrates one synchronous single-port byte memory between the ROM loader,
// the CPU and the video engine, with an optional one-cycle CPU lock.
module chip8_mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_lock,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {
      RR_CPU,
      RR_VID
   } rr_t;

   rr_t  rr_ptr;
   logic lock_q;
   logic rd_cpu_q;
   logic rd_vid_q;

   // A pending lock only wins when the CPU actually asks; otherwise normal arbitration.
   always_comb begin
      ld_gnt  = 1'b0;
      cpu_gnt = 1'b0;
      vid_gnt = 1'b0;
      if (!rst) begin
         if (lock_q && cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (ld_req) begin
            ld_gnt = 1'b1;
         end else if (cpu_req && vid_req) begin
            if (rr_ptr == RR_CPU) cpu_gnt = 1'b1;
            else                  vid_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (vid_req) begin
            vid_gnt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= RR_CPU;
         lock_q     <= 1'b0;
         rd_cpu_q   <= 1'b0;
         rd_vid_q   <= 1'b0;
         cpu_rvalid <= 1'b0;
         vid_rvalid <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         mem_en <= ld_gnt | cpu_gnt | vid_gnt;
         mem_we <= ld_gnt | (cpu_gnt & cpu_we);
         if (ld_gnt) begin
            mem_addr  <= ld_addr;
            mem_wdata <= ld_wdata;
         end else if (cpu_gnt) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
         end else if (vid_gnt) begin
            mem_addr  <= vid_addr;
            mem_wdata <= '0;
         end

         // Two-stage owner pipeline: request stage, then memory data stage.
         rd_cpu_q   <= cpu_gnt & ~cpu_we;
         rd_vid_q   <= vid_gnt;
         cpu_rvalid <= rd_cpu_q;
         vid_rvalid <= rd_vid_q;

         lock_q <= cpu_gnt & cpu_lock & ~lock_q;

         if (cpu_gnt)      rr_ptr <= RR_VID;
         else if (vid_gnt) rr_ptr <= RR_CPU;
      end
   end

   assign rdata = mem_rdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed table-driven bench for chip8_mem_arbiter with a 4 KiB synchronous memory model.
module tb_chip8_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_req, cpu_req, cpu_we, cpu_lock, vid_req;
   logic [11:0] ld_addr, cpu_addr, vid_addr;
   logic [7:0]  ld_wdata, cpu_wdata;
   logic        ld_gnt, cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid;
   logic [7:0]  rdata;
   logic        mem_en, mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   logic [7:0]  mem [4096];

   int checks = 0;
   int errors = 0;

   chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
      .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory: read data appears the cycle after mem_en.
   always @(posedge clk) begin
      if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   typedef struct {
      logic        ld, cpu, we, lk, vid;
      logic [11:0] ld_a;
      logic [7:0]  ld_d;
      logic [11:0] cpu_a;
      logic [7:0]  cpu_d;
      logic [11:0] vid_a;
      logic [2:0]  gnt;   // {ld, cpu, vid}
      logic        en, mwe;
      logic [11:0] maddr;
      logic [7:0]  mwd;
      logic [1:0]  rv;    // {cpu, vid}
      logic [7:0]  rd;
   } vec_t;

   vec_t vecs [26];

   function automatic vec_t mk(input logic ld, cpu, we, lk, vid,
                               input logic [11:0] ld_a, input logic [7:0] ld_d,
                               input logic [11:0] cpu_a, input logic [7:0] cpu_d,
                               input logic [11:0] vid_a, input logic [2:0] gnt,
                               input logic en, mwe, input logic [11:0] maddr,
                               input logic [7:0] mwd, input logic [1:0] rv,
                               input logic [7:0] rd);
      vec_t v;
      v.ld = ld; v.cpu = cpu; v.we = we; v.lk = lk; v.vid = vid;
      v.ld_a = ld_a; v.ld_d = ld_d; v.cpu_a = cpu_a; v.cpu_d = cpu_d; v.vid_a = vid_a;
      v.gnt = gnt; v.en = en; v.mwe = mwe; v.maddr = maddr; v.mwd = mwd;
      v.rv = rv; v.rd = rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ld_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; vid_req = 1'b0;
      ld_addr = '0; ld_wdata = '0; cpu_addr = '0; cpu_wdata = '0; vid_addr = '0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = i[7:0] ^ 8'h3C;
      mem[12'h200] = 8'h6A;
      mem_rdata = '0;

      //          ld cpu we lk vid  ld_a    ld_d   cpu_a   cpu_d  vid_a   gnt     en mwe maddr   mwd    rv     rd
      vecs[0]  = mk(0, 1, 0, 0, 0, 12'h000, 8'h00, 12'h200, 8'h00, 12'h000, 3'b010, 0, 0, 12'h000, 8'h00, 2'b00, 8'h00);
      vecs[1]  = mk(0, 0, 0, 0, 1, 12'h000, 8'h00, 12'h000, 8'h00, 12'h220, 3'b001, 1, 0, 12'h200, 8'h00, 2'b00, 8'h00);
      vecs[2]  = mk(1, 1, 0, 0, 1, 12'h200, 8'h12, 12'h210, 8'h00, 12'h220, 3'b100, 1, 0, 12'h220, 8'h00, 2'b10, 8'h6A);
      vecs[3]  = mk(1, 1, 0, 0, 1, 12'h201, 8'h34, 12'h210, 8'h00, 12'h220, 3'b100, 1, 1, 12'h200, 8'h12, 2'b01, 8'h1C);
      vecs[4]  = mk(1, 1, 0, 0, 1, 12'h202, 8'h56, 12'h210, 8'h00, 12'h220, 3'b100, 1, 1, 12'h201, 8'h34, 2'b00, 8'h00);
      vecs[5]  = mk(0, 1, 0, 0, 1, 12'h000, 8'h00, 12'h210, 8'h00, 12'h220, 3'b010, 1, 1, 12'h202, 8'h56, 2'b00, 8'h00);
      vecs[6]  = mk(0, 1, 0, 0, 1, 12'h000, 8'h00, 12'h210, 8'h00, 12'h220, 3'b001, 1, 0, 12'h210, 8'h00, 2'b00, 8'h00);
      vecs[7]  = mk(0, 1, 0, 0, 1, 12'h000, 8'h00, 12'h201, 8'h00, 12'h202, 3'b010, 1, 0, 12'h220, 8'h00, 2'b10, 8'h2C);
      vecs[8]  = mk(0, 1, 0, 0, 1, 12'h000, 8'h00, 12'h201, 8'h00, 12'h202, 3'b001, 1, 0, 12'h201, 8'h00, 2'b01, 8'h1C);
      vecs[9]  = mk(0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000, 3'b000, 1, 0, 12'h202, 8'h00, 2'b10, 8'h34);
      vecs[10] = mk(0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000, 3'b000, 0, 0, 12'h000, 8'h00, 2'b01, 8'h56);
      vecs[11] = mk(0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000, 3'b000, 0, 0, 12'h000, 8'h00, 2'b00, 8'h00);
      vecs[12] = mk(0, 1, 0, 1, 1, 12'h000, 8'h00, 12'h300, 8'h00, 12'h320, 3'b010, 0, 0, 12'h000, 8'h00, 2'b00, 8'h00);
      vecs[13] = mk(1, 1, 0, 1, 1, 12'h3F0, 8'hAA, 12'h301, 8'h00, 12'h320, 3'b010, 1, 0, 12'h300, 8'h00, 2'b00, 8'h00);
      vecs[14] = mk(0, 1, 0, 0, 1, 12'h000, 8'h00, 12'h302, 8'h00, 12'h320, 3'b001, 1, 0, 12'h301, 8'h00, 2'b10, 8'h3C);
      vecs[15] = mk(1, 0, 0, 0, 0, 12'h3F0, 8'hAA, 12'h000, 8'h00, 12'h000, 3'b100, 1, 0, 12'h320, 8'h00, 2'b10, 8'h3D);
      vecs[16] = mk(0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000, 3'b000, 1, 1, 12'h3F0, 8'hAA, 2'b01, 8'h1C);
      vecs[17] = mk(0, 1, 0, 1, 0, 12'h000, 8'h00, 12'h310, 8'h00, 12'h000, 3'b010, 0, 0, 12'h000, 8'h00, 2'b00, 8'h00);
      vecs[18] = mk(0, 0, 0, 0, 1, 12'h000, 8'h00, 12'h000, 8'h00, 12'h330, 3'b001, 1, 0, 12'h310, 8'h00, 2'b00, 8'h00);
      vecs[19] = mk(0, 1, 1, 0, 0, 12'h000, 8'h00, 12'h3F1, 8'h77, 12'h000, 3'b010, 1, 0, 12'h330, 8'h00, 2'b10, 8'h2C);
      vecs[20] = mk(0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000, 3'b000, 1, 1, 12'h3F1, 8'h77, 2'b01, 8'h0C);
      vecs[21] = mk(0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000, 3'b000, 0, 0, 12'h000, 8'h00, 2'b00, 8'h00);
      vecs[22] = mk(0, 1, 0, 0, 0, 12'h000, 8'h00, 12'h3F0, 8'h00, 12'h000, 3'b010, 0, 0, 12'h000, 8'h00, 2'b00, 8'h00);
      vecs[23] = mk(0, 1, 0, 0, 0, 12'h000, 8'h00, 12'h3F1, 8'h00, 12'h000, 3'b010, 1, 0, 12'h3F0, 8'h00, 2'b00, 8'h00);
      vecs[24] = mk(0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000, 3'b000, 1, 0, 12'h3F1, 8'h00, 2'b10, 8'hAA);
      vecs[25] = mk(0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000, 3'b000, 0, 0, 12'h000, 8'h00, 2'b10, 8'h77);

      // Reset state, with requests present to confirm grants are forced low.
      idle_inputs();
      rst = 1'b1;
      ld_req = 1'b1; cpu_req = 1'b1; vid_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_gnt", {29'd0, ld_gnt, cpu_gnt, vid_gnt}, 32'd0);
      chk("reset_rvalid", {30'd0, cpu_rvalid, vid_rvalid}, 32'd0);
      chk("reset_mem_ctl", {30'd0, mem_en, mem_we}, 32'd0);
      chk("reset_mem_addr", {20'd0, mem_addr}, 32'd0);
      chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      idle_inputs();
      @(posedge clk);
      #1 rst = 1'b0;

      for (int s = 0; s < 26; s++) begin
         @(posedge clk);
         #1;
         ld_req = vecs[s].ld; cpu_req = vecs[s].cpu; cpu_we = vecs[s].we;
         cpu_lock = vecs[s].lk; vid_req = vecs[s].vid;
         ld_addr = vecs[s].ld_a; ld_wdata = vecs[s].ld_d;
         cpu_addr = vecs[s].cpu_a; cpu_wdata = vecs[s].cpu_d; vid_addr = vecs[s].vid_a;
         @(negedge clk);
         chk($sformatf("gnt step %0d", s), {29'd0, ld_gnt, cpu_gnt, vid_gnt}, {29'd0, vecs[s].gnt});
         chk($sformatf("mem_en step %0d", s), {31'd0, mem_en}, {31'd0, vecs[s].en});
         chk($sformatf("mem_we step %0d", s), {31'd0, mem_we}, {31'd0, vecs[s].mwe});
         if (vecs[s].en)
            chk($sformatf("mem_addr step %0d", s), {20'd0, mem_addr}, {20'd0, vecs[s].maddr});
         if (vecs[s].mwe)
            chk($sformatf("mem_wdata step %0d", s), {24'd0, mem_wdata}, {24'd0, vecs[s].mwd});
         chk($sformatf("rvalid step %0d", s), {30'd0, cpu_rvalid, vid_rvalid}, {30'd0, vecs[s].rv});
         if (vecs[s].rv != 2'b00)
            chk($sformatf("rdata step %0d", s), {24'd0, rdata}, {24'd0, vecs[s].rd});
      end

      chk("model_mem_200", {24'd0, mem[12'h200]}, 32'h12);
      chk("model_mem_201", {24'd0, mem[12'h201]}, 32'h34);
      chk("model_mem_202", {24'd0, mem[12'h202]}, 32'h56);

      // Reset one cycle after a CPU read is accepted: the read must never return.
      @(posedge clk);
      #1;
      idle_inputs();
      cpu_req = 1'b1; cpu_addr = 12'h3F0;
      @(negedge clk);
      chk("midrst_gnt", {31'd0, cpu_gnt}, 32'd1);
      @(posedge clk);
      #1;
      chk("midrst_mem_en_pre", {31'd0, mem_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_gnt_forced", {29'd0, ld_gnt, cpu_gnt, vid_gnt}, 32'd0);
      chk("midrst_mem_ctl", {30'd0, mem_en, mem_we}, 32'd0);
      chk("midrst_mem_addr", {20'd0, mem_addr}, 32'd0);
      chk("midrst_rvalid", {30'd0, cpu_rvalid, vid_rvalid}, 32'd0);
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("midrst_no_rvalid %0d", c), {30'd0, cpu_rvalid, vid_rvalid}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
- Shares one synchronous single-port byte memory (ROM/RAM image, 4 KiB) between three requesters.
- Requesters: the ROM loader (boot-time writes), the CPU (2-byte opcode fetch plus data reads/writes), and the video engine (sprite/framebuffer reads).
- Strict priority for the loader; round-robin between CPU and video.
- Optional one-cycle lock so the CPU's two opcode bytes are fetched back-to-back.

Parameters:
- ADDR_W, 12, byte address width (4096 bytes).
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_req  in  1  loader request (always a write).
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_gnt  out  1  loader grant (combinational).
- cpu_req  in  1  CPU request.
- cpu_we  in  1  CPU write enable (1 = write, 0 = read).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_lock  in  1  reserve the next cycle for the CPU.
- cpu_gnt  out  1  CPU grant (combinational).
- cpu_rvalid  out  1  CPU read data valid.
- vid_req  in  1  video read request.
- vid_addr  in  ADDR_W  video address.
- vid_gnt  out  1  video grant (combinational).
- vid_rvalid  out  1  video read data valid.
- rdata  out  DATA_W  read data, shared by all requesters, qualified by the *_rvalid strobes.
- mem_en  out  1  memory enable (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async, rst=1):
  - All gnt outputs are 0 (forced while rst=1).
  - cpu_rvalid, vid_rvalid, mem_en, mem_we are 0.
  - mem_addr and mem_wdata are 0.
  - The round-robin pointer is set to CPU-first.
  - Lock is cleared.
  - Any in-flight read is discarded; no rvalid is issued after reset release for a pre-reset read.
- Handshake:
  - Grant is combinational from the req inputs and internal state.
  - A transaction is accepted at the rising edge where req && gnt.
  - A requester holds req, addr and wdata stable until it sees gnt.
  - At most one gnt is high per cycle.
- Priority, when not locked: loader > (CPU vs video by round-robin).
  - The round-robin pointer flips to the other requester after each accepted CPU or video grant.
  - Loader grants leave the pointer unchanged.
  - A lone requester is granted regardless of the pointer.
- Lock:
  - If a CPU transaction is accepted with cpu_lock=1, the next cycle is locked.
  - In a locked cycle, cpu_req is granted even over ld_req and vid_req.
  - cpu_lock is ignored in a locked cycle, so lock spans at most one extra cycle and cannot chain.
  - If cpu_req=0 in the locked cycle, the lock expires unused and normal arbitration applies that same cycle.
  - A locked CPU grant also flips the pointer to video.
- Memory timing:
  - Accepted at edge E: mem_en=1, mem_we, mem_addr and mem_wdata are registered and held for the cycle after E.
  - mem_en=0 in any cycle following an edge with no acceptance; mem_we is also 0 then.
- Read latency:
  - For a read accepted at edge E, the owner's rvalid is 1 for exactly one cycle, two edges after E.
  - rdata = mem_rdata during that cycle.
  - Writes produce no rvalid.
  - Back-to-back reads are pipelined at one per cycle; the rvalid strobes follow acceptance order.
- Address width is fixed at ADDR_W; no wrap or bounds checking. The requester masks 0xFFF.
- Simultaneous accepted write and pending read-return: both proceed, because the pipeline stages are independent.

Test Plan:
- Reset, single CPU read: release rst; cpu_req=1, we=0, addr=0x200.
  - cpu_gnt=1 same cycle.
  - Next cycle mem_en=1, mem_we=0, mem_addr=0x200.
  - Following cycle: cpu_rvalid=1 for one cycle, rdata=mem_rdata model value (e.g. 0x6A).
- Loader priority: ld_req, cpu_req and vid_req all held for 3 cycles; ld writes 0x200=0x12, 0x201=0x34, 0x202=0x56.
  - Only ld_gnt during those 3 cycles.
  - The model memory holds the written values.
  - The next grant goes to the CPU (pointer unchanged).
- Round-robin: cpu_req and vid_req held continuously for 4 cycles.
  - Grants are CPU, video, CPU, video.
  - Each rvalid follows its grant by 2 edges to the correct owner.
- Lock fetch: CPU reads 0x300 with cpu_lock=1 while vid_req is held high; next cycle CPU reads 0x301, also with cpu_lock=1.
  - Both bytes are granted consecutively.
  - Video is granted on the third cycle (no lock chain).
  - ld_req asserted during the locked cycle is still deferred.
- Unused lock: CPU accepted with cpu_lock=1, then cpu_req=0 with vid_req=1.
  - vid_gnt=1 in that cycle.
- Reset mid-read: assert rst one cycle after a CPU read is accepted.
  - All outputs go to 0 immediately.
  - No cpu_rvalid occurs after rst is released.
